seg7_s2p_rx: RTL and testbench

//  Serial-to-parallel receiver for the 4-wire 7-segment serial link (s_clk, s_clrn, sout, EN).

---
 rtl/seg_pkg.sv | 13 +
 rtl/sync_edge.sv | 40 ++++
 rtl/seg7_s2p_rx.sv | 118 +++++++++++
 tb/tb_seg7_s2p_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment serial-link receiver.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    SHIFT   = 2'd2,
    WAIT_EN = 2'd3
  } rx_state_e;

  localparam int SEG_FRAME_BITS = 64;

endpackage

// File: rtl/sync_edge.sv
// Synchronizes one asynchronous serial-link wire into clk and produces registered
// rise/fall strobes plus a level that is time-aligned with those strobes.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  // prev_q carries the same sample that produced the current strobe, so data
  // wires read through level_o line up with the s_clk rise strobe.
  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/seg7_s2p_rx.sv
// Oversampling serial-to-parallel receiver for the 4-wire 7-segment link:
// rebuilds DATA_BITS-wide frames and flags short or overrun frames.
module seg7_s2p_rx
  import seg_pkg::*;
#(
  parameter int DATA_BITS   = SEG_FRAME_BITS,
  parameter int DIR         = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_clk,
  input  logic                 s_clrn,
  input  logic                 sout,
  input  logic                 en,
  output logic [DATA_BITS-1:0] pdata,
  output logic                 pdata_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int             CW   = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]  LAST = CW'(DATA_BITS - 1);

  logic sclk_rise, en_rise, clrn_lvl, sout_lvl;
  logic sclk_lvl_unused, sclk_fall_unused;
  logic en_lvl_unused, en_fall_unused;
  logic clrn_rise_unused, clrn_fall_unused;
  logic sout_rise_unused, sout_fall_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(s_clk),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_en (
    .clk(clk), .rst(rst), .d_i(en),
    .level_o(en_lvl_unused), .rise_o(en_rise), .fall_o(en_fall_unused)
  );

  // Resets high so leaving reset never looks like a frame start.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clrn (
    .clk(clk), .rst(rst), .d_i(s_clrn),
    .level_o(clrn_lvl), .rise_o(clrn_rise_unused), .fall_o(clrn_fall_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sout (
    .clk(clk), .rst(rst), .d_i(sout),
    .level_o(sout_lvl), .rise_o(sout_rise_unused), .fall_o(sout_fall_unused)
  );

  rx_state_e             state_q;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [CW-1:0]         cnt_q;
  logic [DATA_BITS-1:0]  pdata_q;
  logic                  pdata_valid_q;
  logic                  frame_err_q;

  always_comb begin
    shift_d = shift_q;
    if (DIR == 0) shift_d = {shift_q[DATA_BITS-2:0], sout_lvl};
    else          shift_d = {sout_lvl, shift_q[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      pdata_q       <= '0;
      pdata_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      pdata_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      if (!clrn_lvl) begin
        state_q <= CLEAR;
        shift_q <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE:  ;
          CLEAR: state_q <= SHIFT;
          SHIFT: begin
            if (sclk_rise) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + CW'(1);
            end
            // An en rise here is always short, even when it coincides with the last bit.
            if (en_rise) begin
              frame_err_q <= 1'b1;
              state_q     <= IDLE;
            end else if (sclk_rise && cnt_q == LAST) begin
              state_q <= WAIT_EN;
            end
          end
          WAIT_EN: begin
            if (en_rise) begin
              pdata_q       <= shift_q;
              pdata_valid_q <= 1'b1;
              state_q       <= IDLE;
            end else if (sclk_rise) begin
              frame_err_q <= 1'b1;
              state_q     <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pdata       = pdata_q;
  assign pdata_valid = pdata_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q == SHIFT) || (state_q == WAIT_EN);

endmodule

// File: tb/tb_seg7_s2p_rx.sv
// Self-checking bench: drives two receivers (MSB-first and LSB-first) from one link
// and compares them against a bit-queue model of the frame rules.
module tb_seg7_s2p_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_clk = 1'b0, s_clrn = 1'b1, sout = 1'b0, en = 1'b0;
  logic [63:0] pdata0, pdata1;
  logic v0, v1, e0, e1, b0, b1;

  seg7_s2p_rx #(.DATA_BITS(64), .DIR(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_clrn(s_clrn), .sout(sout), .en(en),
    .pdata(pdata0), .pdata_valid(v0), .frame_err(e0), .busy(b0)
  );

  seg7_s2p_rx #(.DATA_BITS(64), .DIR(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_clrn(s_clrn), .sout(sout), .en(en),
    .pdata(pdata1), .pdata_valid(v1), .frame_err(e1), .busy(b1)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, en_cyc = 0, v_cyc = 0;
  int nv0 = 0, nv1 = 0, ne0 = 0, ne1 = 0;
  int exp_nv = 0, exp_ne = 0;
  logic [63:0] exp_p0 = '0, exp_p1 = '0;
  bit m_active = 0;
  bit m_bits[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v0) begin nv0++; v_cyc = cyc; end
    if (v1) nv1++;
    if (e0) ne0++;
    if (e1) ne1++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clrn();
    s_clrn = 1'b0;
    tick(3);
    s_clrn = 1'b1;
    m_active = 1;
    m_bits.delete();
    tick(3);
  endtask

  task automatic send_bit(input bit b, input bit with_en);
    sout = b;
    tick(2);
    s_clk = 1'b1;
    if (with_en) en = 1'b1;
    if (m_active) begin
      m_bits.push_back(b);
      if (m_bits.size() > 64 || with_en) begin
        exp_ne++;
        m_active = 0;
      end
    end
    tick(3);
    s_clk = 1'b0;
    en = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) send_bit(d[63 - (i % 64)], 1'b0);
  endtask

  task automatic send_en();
    en = 1'b1;
    en_cyc = cyc;
    if (m_active) begin
      if (m_bits.size() == 64) begin
        exp_nv++;
        for (int i = 0; i < 64; i++) begin
          exp_p0[63 - i] = m_bits[i];
          exp_p1[i]      = m_bits[i];
        end
      end else begin
        exp_ne++;
      end
      m_active = 0;
    end
    tick(3);
    en = 1'b0;
    tick(2);
  endtask

  task automatic check_all(input string tag);
    tick(6);
    chk({tag, ".valid0"}, 64'(nv0), 64'(exp_nv));
    chk({tag, ".valid1"}, 64'(nv1), 64'(exp_nv));
    chk({tag, ".err0"},   64'(ne0), 64'(exp_ne));
    chk({tag, ".err1"},   64'(ne1), 64'(exp_ne));
    chk({tag, ".pdata0"}, pdata0, exp_p0);
    chk({tag, ".pdata1"}, pdata1, exp_p1);
    chk({tag, ".busy0"},  64'(b0), 64'(m_active));
    chk({tag, ".busy1"},  64'(b1), 64'(m_active));
    $display("txn %s: pdata0=%h pdata1=%h valids=%0d errs=%0d", tag, pdata0, pdata1, nv0, ne0);
  endtask

  initial begin
    logic [63:0] d;
    int kind, len;

    tick(3);
    chk("reset.pdata0", pdata0, 64'h0);
    chk("reset.pdata1", pdata1, 64'h0);
    chk("reset.flags", {61'h0, v0, e0, b0}, 64'h0);
    rst = 1'b0;
    tick(3);

    // Edges before any clrn are ignored.
    send_bit(1'b1, 1'b0);
    send_en();
    check_all("idle_stray");

    do_clrn();
    send_frame(64'hC0F9_A4B0_9992_82F8, 64);
    send_en();
    check_all("good_c0f9");
    chk("latency", 64'(v_cyc - en_cyc), 64'd4);
    chk("good_c0f9.lit", pdata0, 64'hC0F9_A4B0_9992_82F8);

    do_clrn();
    send_frame(64'h1111_2222_3333_4444, 63);
    send_en();
    check_all("short63");

    do_clrn();
    send_frame(64'hDEAD_BEEF_0BAD_F00D, 65);
    check_all("overrun");
    send_en();
    do_clrn();
    send_frame(64'h5A5A_0FF0_1234_8765, 64);
    send_en();
    check_all("after_overrun");

    do_clrn();
    send_frame(64'hFFFF_0000_AAAA_5555, 30);
    do_clrn();
    send_frame(64'h0123_4567_89AB_CDEF, 64);
    send_en();
    check_all("restart");
    chk("restart.lit", pdata0, 64'h0123_4567_89AB_CDEF);

    // en rise coinciding with the 64th s_clk rise is still a short frame.
    do_clrn();
    send_frame(64'h7777_8888_9999_AAAA, 63);
    send_bit(1'b1, 1'b1);
    check_all("simul_edge");

    for (int it = 0; it < 12; it++) begin
      d = {$urandom, $urandom};
      kind = $urandom_range(0, 4);
      do_clrn();
      case (kind)
        0, 1: begin send_frame(d, 64); send_en(); end
        2: begin len = $urandom_range(1, 63); send_frame(d, len); send_en(); end
        3: begin send_frame(d, 65); send_en(); end
        default: begin
          len = $urandom_range(1, 60);
          send_frame(~d, len);
          do_clrn();
          send_frame(d, 64);
          send_en();
        end
      endcase
      check_all($sformatf("rand%0d_k%0d", it, kind));
    end

    do_clrn();
    send_frame(64'hCAFE_F00D_1357_9BDF, 40);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_async.pdata0", pdata0, 64'h0);
    chk("rst_async.pdata1", pdata1, 64'h0);
    chk("rst_async.flags", {61'h0, v0, e0, b0}, 64'h0);
    exp_p0 = '0;
    exp_p1 = '0;
    m_active = 0;
    m_bits.delete();
    tick(2);
    rst = 1'b0;
    tick(2);
    send_frame(64'hF0F0_F0F0_F0F0_F0F0, 5);
    send_en();
    check_all("post_reset_stray");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
